// File: rtl/capture_sender_pkg.sv
// Shared capture-memory geometry and sender state encoding.
// Imported by the monitor and the sender so memory layout always agrees.
package capture_sender_pkg;

    localparam int MEM_ADDRESS_BITS = 8;
    localparam int MEM_WORDLEN_BITS = 16;
    localparam int MEM_LAST_ADDR    = 255;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ACK       = 4'd1,
        S_READ      = 4'd2,
        S_RD_WAIT   = 4'd3,
        S_LOAD      = 4'd4,
        S_SEND      = 4'd5,
        S_TX_SETTLE = 4'd6,
        S_TX_WAIT   = 4'd7,
        S_NEXT      = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    // Width of a byte-index counter; never narrower than one bit.
    function automatic int idx_bits(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/capture_sender_shifter.sv
// word_byte_shifter: holds one memory word and presents its top byte.
// Ports: clk, rst_l, load/word (capture), advance (shift left 8), byte_out.
module word_byte_shifter #(
    parameter int WIDTH = capture_sender_pkg::MEM_WORDLEN_BITS
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] word,
    output logic [7:0]       byte_out
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sr <= '0;
        end else if (load) begin
            sr <= word;
        end else if (advance) begin
            sr <= sr << 8;
        end
    end

    assign byte_out = sr[WIDTH-1 -: 8];

endmodule

// File: rtl/capture_sender.sv
// capture_sender: after sc_run, sweeps capture memory from the last address
// down to 0 and streams each word MSB byte first to the UART.
// Ports: clk, rst_l, sc_run/ack_sc_run/sc_done (monitor handshake),
//        mem_port_B_address/mem_port_B_dout (RAM read, 1-cycle latency),
//        tx_data/tx_start/tx_busy (UART transmitter).
module capture_sender #(
    parameter int MEM_ADDRESS_BITS = capture_sender_pkg::MEM_ADDRESS_BITS,
    parameter int MEM_WORDLEN_BITS = capture_sender_pkg::MEM_WORDLEN_BITS,
    parameter int MEM_LAST_ADDR    = capture_sender_pkg::MEM_LAST_ADDR
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        sc_run,
    output logic                        ack_sc_run,
    output logic                        sc_done,
    output logic [MEM_ADDRESS_BITS-1:0] mem_port_B_address,
    input  logic [MEM_WORDLEN_BITS-1:0] mem_port_B_dout,
    output logic [7:0]                  tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy
);

    import capture_sender_pkg::*;

    localparam int BYTES = MEM_WORDLEN_BITS / 8;
    localparam int IW    = idx_bits(BYTES);

    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
    localparam logic [MEM_ADDRESS_BITS-1:0] LAST_ADDR =
        MEM_ADDRESS_BITS'(MEM_LAST_ADDR);

    state_t                      state;
    state_t                      state_nxt;
    logic [MEM_ADDRESS_BITS-1:0] addr;
    logic [MEM_ADDRESS_BITS-1:0] mem_addr;
    logic [IW-1:0]               idx;
    logic [7:0]                  tx_hold;
    logic [7:0]                  cur_byte;
    logic                        done_q;
    logic                        load;
    logic                        advance;
    logic                        more_bytes;
    logic                        at_zero;

    assign more_bytes = idx < LAST_IDX;
    assign at_zero    = addr == '0;

    word_byte_shifter #(
        .WIDTH(MEM_WORDLEN_BITS)
    ) u_shift (
        .clk     (clk),
        .rst_l   (rst_l),
        .load    (load),
        .advance (advance),
        .word    (mem_port_B_dout),
        .byte_out(cur_byte)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // TX_SETTLE absorbs the UART's busy latency; a UART that is already
    // busy there is waited out in TX_WAIT, otherwise we move straight on.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (sc_run) state_nxt = S_ACK;
            S_ACK:       state_nxt = S_READ;
            S_READ:      state_nxt = S_RD_WAIT;
            S_RD_WAIT:   state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_SEND;
            S_SEND:      if (!tx_busy) state_nxt = S_TX_SETTLE;
            S_TX_SETTLE: state_nxt = tx_busy ? S_TX_WAIT : S_NEXT;
            S_TX_WAIT:   if (!tx_busy) state_nxt = S_NEXT;
            S_NEXT: begin
                if (more_bytes)   state_nxt = S_SEND;
                else if (at_zero) state_nxt = S_DONE;
                else              state_nxt = S_READ;
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // tx_data shows the live byte during the start pulse and the
    // captured copy afterwards, so it holds until the next start.
    always_comb begin
        ack_sc_run = state == S_ACK;
        tx_start   = (state == S_SEND) && !tx_busy;
        load       = state == S_LOAD;
        advance    = (state == S_NEXT) && more_bytes;
        tx_data    = tx_start ? cur_byte : tx_hold;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            addr     <= LAST_ADDR;
            mem_addr <= '0;
            idx      <= '0;
            tx_hold  <= '0;
            done_q   <= 1'b0;
        end else begin
            if (state == S_ACK) begin
                addr   <= LAST_ADDR;
                done_q <= 1'b0;
            end
            if (state == S_READ) mem_addr <= addr;
            if (load)            idx <= '0;
            if (advance)         idx <= idx + 1'b1;
            if (tx_start)        tx_hold <= cur_byte;
            if (state == S_NEXT && !more_bytes) begin
                if (at_zero) done_q <= 1'b1;
                else         addr <= addr - 1'b1;
            end
        end
    end

    assign sc_done            = done_q;
    assign mem_port_B_address = mem_addr;

endmodule
